sd_operand_feeder: RTL and testbench
====================================

// Module: sd_operand_feeder
// PURPOSE
//  Upstream stage of the online multiplier control path. Accepts whole signed-digit operand
//  vectors (X, Y) via valid/ready and streams them MSD-first, one digit pair per request, to
//  the computation controller's x_in/y_in with enable_comp. Appends ONLINE_DELAY zero digits
//  per vector; double-buffers so back-to-back vectors stream without a bubble.
// PARAMETERS
//  UNROLLING     64  digits per operand vector
//  ONLINE_DELAY  2   zero digits appended after each vector (matches controller delay)
//  CNT_W         11  width of digit_idx
// PORTS
//  clk           in   1            rising-edge clock
//  asyn_reset_n  in   1            reset, asynchronous, active-low
//  flush         in   1            synchronous clear of both slots and FSM
//  load_valid    in   1            x_vec/y_vec valid
//  load_ready    out  1            pending slot empty; load accepted when valid&ready
//  x_vec         in   2*UNROLLING  X digits; digit k at [2k+1:2k], k=UNROLLING-1 is MSD
//  y_vec         in   2*UNROLLING  Y digits, same layout
//  digit_req     in   1            consumer requests next digit pair
//  x_digit       out  2            X digit: 00=0, 01=+1, 10=-1
//  y_digit       out  2            Y digit, same encoding
//  enable_comp   out  1            high while a vector is streaming (STREAM or PAD)
//  digit_idx     out  CNT_W        index of digit last presented (0..UNROLLING+ONLINE_DELAY-1)
//  last_digit    out  1            high with final pad digit of a vector
//  enc_error     out  1            sticky: a loaded digit was 11
// BEHAVIOUR
//  Reset (async, asyn_reset_n=0) and flush: FSM=IDLE, both slots empty, x/y_digit=00,
//   enable_comp=0, digit_idx=0, last_digit=0, load_ready=1, enc_error=0. Reset mid-stream
//   abandons the vector; no partial output after release.
//  Slots: ACTIVE (streaming) and PENDING. Load writes PENDING; if ACTIVE is empty, PENDING
//   moves to ACTIVE on the next edge. load_ready = !pending_full (registered, no same-cycle
//   bypass: a load coinciding with a swap is not accepted that cycle).
//  Encoding check at load: any 11 digit sets enc_error and is stored as 00.
//  FSM:
//   IDLE   : enable_comp=0. ACTIVE full -> STREAM, idx=0.
//   STREAM : on digit_req, register ACTIVE digit (UNROLLING-1-idx) onto x/y_digit next edge,
//            digit_idx<=idx, idx++. After digit UNROLLING-1 is issued -> PAD.
//   PAD    : on digit_req, output 00/00, idx++. On the ONLINE_DELAY-th pad digit assert
//            last_digit (one cycle, aligned with that digit), free ACTIVE; if PENDING full,
//            swap in the same edge and -> STREAM idx=0 (no bubble), else -> IDLE.
//            ONLINE_DELAY=0: last_digit on digit UNROLLING-1 instead, PAD skipped.
//  Latency: digit appears one cycle after its digit_req; without digit_req outputs hold.
//  enable_comp rises the cycle after entering STREAM, falls the cycle after entering IDLE.
//  digit_req in IDLE is ignored (no output change). flush has priority over load and req.
//  Width: idx counts 0..UNROLLING+ONLINE_DELAY-1, never wraps; CNT_W must cover it.
// STRUCTURE
//  Package sd_pkg: SD_ZERO/SD_POS/SD_NEG/SD_BAD 2-bit constants; FSM enum
//   {FEED_IDLE, FEED_STREAM, FEED_PAD}; shared with the computation controller.
//  Sub-module sd_digit_select: combinational MSD-first digit mux (vector, idx) -> digit,
//   instantiated for X and Y. FSM, slots and counters live in the top.
// TESTING
//  1 Reset: drive asyn_reset_n=0 mid-STREAM at idx 10 -> all outputs reset values next
//    sample, load_ready=1, no digits after release until new load.
//  2 Single vector: X=all +1 (01), Y=alternating +1/-1 from MSD, digit_req held 1 ->
//    66 digit pairs in order, last two 00/00, last_digit on digit_idx=65, then IDLE.
//  3 Back-to-back: load A, load B during A's stream -> load_ready=0 after B; B's MSD
//    follows A's last pad with no gap; load_ready returns 1 at swap+1.
//  4 Stalled requests: digit_req pulsed every 3rd cycle -> outputs hold between
//    requests; sequence identical to test 2.
//  5 Bad encoding: load with digit 37 = 11 -> enc_error=1 sticky, that digit emitted 00.
//  6 Flush mid-PAD with PENDING full -> both slots empty, IDLE, enable_comp=0 next cycle.

Source files
------------

// File: rtl/sd_pkg.sv
// -----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the online multiplier control path: the 2-bit
// signed-digit encoding and the operand feeder FSM states. The computation
// controller imports the same package, so both ends agree on the encoding.
// -----------------------------------------------------------------------------
package sd_pkg;

  // Signed-digit encoding. 11 is not a legal digit.
  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_POS  = 2'b01;
  localparam logic [1:0] SD_NEG  = 2'b10;
  localparam logic [1:0] SD_BAD  = 2'b11;

  typedef enum logic [1:0] {
    FEED_IDLE   = 2'd0,
    FEED_STREAM = 2'd1,
    FEED_PAD    = 2'd2
  } feed_state_e;

  // Illegal digits are replaced by zero so they cannot disturb the datapath.
  function automatic logic [1:0] sd_sanitize(input logic [1:0] d);
    return (d == SD_BAD) ? SD_ZERO : d;
  endfunction

endpackage

// File: rtl/sd_digit_select.sv
// -----------------------------------------------------------------------------
// sd_digit_select
// Combinational MSD-first digit mux. Index 0 selects the most significant
// digit (vector position UNROLLING-1); indices past the vector give zero.
// Ports:
//   vec_i    in  2*UNROLLING  digit vector, digit k at [2k+1:2k]
//   idx_i    in  CNT_W        MSD-first digit index
//   digit_o  out 2            selected digit
// -----------------------------------------------------------------------------
module sd_digit_select
  import sd_pkg::*;
#(
  parameter int UNROLLING = 64,
  parameter int CNT_W     = 11
) (
  input  logic [2*UNROLLING-1:0] vec_i,
  input  logic [CNT_W-1:0]       idx_i,
  output logic [1:0]             digit_o
);

  always_comb begin
    digit_o = SD_ZERO;
    for (int k = 0; k < UNROLLING; k++) begin
      if (idx_i == CNT_W'(UNROLLING - 1 - k)) begin
        digit_o = vec_i[2*k +: 2];
      end
    end
  end

endmodule

// File: rtl/sd_operand_feeder.sv
// -----------------------------------------------------------------------------
// sd_operand_feeder
// Accepts whole signed-digit operand vectors (X, Y) and streams them MSD-first,
// one digit pair per digit_req, followed by ONLINE_DELAY zero pad digits.
// Two slots (ACTIVE, PENDING) let back-to-back vectors stream with no bubble.
// Ports:
//   clk, asyn_reset_n    clock, asynchronous active-low reset
//   flush                synchronous clear of slots and FSM (highest priority)
//   load_valid/ready     vector handshake; ready = PENDING slot empty
//   x_vec, y_vec         operand vectors, digit UNROLLING-1 is the MSD
//   digit_req            request for the next digit pair
//   x_digit, y_digit     digit pair, valid one cycle after its request
//   enable_comp          high while a vector is streaming (lags FSM by a cycle)
//   digit_idx            index of the digit pair last presented
//   last_digit           one-cycle pulse with the final digit of a vector
//   enc_error            sticky flag: an illegal 11 digit was loaded
// -----------------------------------------------------------------------------
module sd_operand_feeder
  import sd_pkg::*;
#(
  parameter int UNROLLING    = 64,
  parameter int ONLINE_DELAY = 2,
  parameter int CNT_W        = 11
) (
  input  logic                   clk,
  input  logic                   asyn_reset_n,
  input  logic                   flush,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [2*UNROLLING-1:0] x_vec,
  input  logic [2*UNROLLING-1:0] y_vec,
  input  logic                   digit_req,
  output logic [1:0]             x_digit,
  output logic [1:0]             y_digit,
  output logic                   enable_comp,
  output logic [CNT_W-1:0]       digit_idx,
  output logic                   last_digit,
  output logic                   enc_error
);

  // CNT_W must be wide enough to hold UNROLLING+ONLINE_DELAY-1.
  localparam logic [CNT_W-1:0] LAST_DATA_IDX = CNT_W'(UNROLLING - 1);
  localparam logic [CNT_W-1:0] LAST_IDX      = CNT_W'(UNROLLING + ONLINE_DELAY - 1);

  // Load-side sanitising: illegal digits become zero and raise a flag.
  logic [2*UNROLLING-1:0] x_clean, y_clean;
  logic [UNROLLING-1:0]   x_bad, y_bad;

  for (genvar gi = 0; gi < UNROLLING; gi++) begin : g_clean
    assign x_bad[gi]            = (x_vec[2*gi +: 2] == SD_BAD);
    assign y_bad[gi]            = (y_vec[2*gi +: 2] == SD_BAD);
    assign x_clean[2*gi +: 2]   = sd_sanitize(x_vec[2*gi +: 2]);
    assign y_clean[2*gi +: 2]   = sd_sanitize(y_vec[2*gi +: 2]);
  end

  feed_state_e            state_q, state_d;
  logic [2*UNROLLING-1:0] active_x_q, active_x_d, active_y_q, active_y_d;
  logic [2*UNROLLING-1:0] pending_x_q, pending_x_d, pending_y_q, pending_y_d;
  logic                   active_full_q, active_full_d;
  logic                   pending_full_q, pending_full_d;
  logic [CNT_W-1:0]       idx_q, idx_d;
  logic [1:0]             x_digit_q, x_digit_d, y_digit_q, y_digit_d;
  logic [CNT_W-1:0]       digit_idx_q, digit_idx_d;
  logic                   last_digit_q, last_digit_d;
  logic                   enable_comp_q, enable_comp_d;
  logic                   enc_error_q, enc_error_d;

  logic [1:0] sel_x, sel_y;
  logic       release_active;
  logic       load_fire;

  sd_digit_select #(.UNROLLING(UNROLLING), .CNT_W(CNT_W)) u_sel_x (
    .vec_i   (active_x_q),
    .idx_i   (idx_q),
    .digit_o (sel_x)
  );

  sd_digit_select #(.UNROLLING(UNROLLING), .CNT_W(CNT_W)) u_sel_y (
    .vec_i   (active_y_q),
    .idx_i   (idx_q),
    .digit_o (sel_y)
  );

  // load_ready comes straight from a register: a load that coincides with a
  // PENDING->ACTIVE move is simply retried next cycle.
  assign load_fire = load_valid && !pending_full_q;

  always_comb begin
    state_d        = state_q;
    active_x_d     = active_x_q;
    active_y_d     = active_y_q;
    active_full_d  = active_full_q;
    pending_x_d    = pending_x_q;
    pending_y_d    = pending_y_q;
    pending_full_d = pending_full_q;
    idx_d          = idx_q;
    x_digit_d      = x_digit_q;
    y_digit_d      = y_digit_q;
    digit_idx_d    = digit_idx_q;
    last_digit_d   = 1'b0;
    enable_comp_d  = (state_q != FEED_IDLE);
    enc_error_d    = enc_error_q;
    release_active = 1'b0;

    case (state_q)
      FEED_IDLE: begin
        if (active_full_q) begin
          state_d = FEED_STREAM;
          idx_d   = '0;
        end
      end
      FEED_STREAM: begin
        if (digit_req) begin
          x_digit_d   = sel_x;
          y_digit_d   = sel_y;
          digit_idx_d = idx_q;
          idx_d       = idx_q + CNT_W'(1);
          if (idx_q == LAST_DATA_IDX) begin
            if (ONLINE_DELAY == 0) begin
              last_digit_d   = 1'b1;
              release_active = 1'b1;
            end else begin
              state_d = FEED_PAD;
            end
          end
        end
      end
      FEED_PAD: begin
        if (digit_req) begin
          x_digit_d   = SD_ZERO;
          y_digit_d   = SD_ZERO;
          digit_idx_d = idx_q;
          idx_d       = idx_q + CNT_W'(1);
          if (idx_q == LAST_IDX) begin
            last_digit_d   = 1'b1;
            release_active = 1'b1;
          end
        end
      end
      default: state_d = FEED_IDLE;
    endcase

    // End of vector: continue straight into a waiting vector, else go idle.
    if (release_active) begin
      active_full_d = 1'b0;
      if (pending_full_q) begin
        state_d = FEED_STREAM;
        idx_d   = '0;
      end else begin
        state_d = FEED_IDLE;
      end
    end

    // PENDING moves up whenever ACTIVE is (or is becoming) free.
    if ((!active_full_q || release_active) && pending_full_q) begin
      active_x_d     = pending_x_q;
      active_y_d     = pending_y_q;
      active_full_d  = 1'b1;
      pending_full_d = 1'b0;
    end

    // Exclusive with the move above, since a load needs PENDING empty.
    if (load_fire) begin
      pending_x_d    = x_clean;
      pending_y_d    = y_clean;
      pending_full_d = 1'b1;
      if ((|x_bad) || (|y_bad)) begin
        enc_error_d = 1'b1;
      end
    end

    if (flush) begin
      state_d        = FEED_IDLE;
      active_full_d  = 1'b0;
      pending_full_d = 1'b0;
      idx_d          = '0;
      x_digit_d      = SD_ZERO;
      y_digit_d      = SD_ZERO;
      digit_idx_d    = '0;
      last_digit_d   = 1'b0;
      enable_comp_d  = 1'b0;
      enc_error_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge asyn_reset_n) begin
    if (!asyn_reset_n) begin
      state_q        <= FEED_IDLE;
      active_x_q     <= '0;
      active_y_q     <= '0;
      active_full_q  <= 1'b0;
      pending_x_q    <= '0;
      pending_y_q    <= '0;
      pending_full_q <= 1'b0;
      idx_q          <= '0;
      x_digit_q      <= SD_ZERO;
      y_digit_q      <= SD_ZERO;
      digit_idx_q    <= '0;
      last_digit_q   <= 1'b0;
      enable_comp_q  <= 1'b0;
      enc_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      active_x_q     <= active_x_d;
      active_y_q     <= active_y_d;
      active_full_q  <= active_full_d;
      pending_x_q    <= pending_x_d;
      pending_y_q    <= pending_y_d;
      pending_full_q <= pending_full_d;
      idx_q          <= idx_d;
      x_digit_q      <= x_digit_d;
      y_digit_q      <= y_digit_d;
      digit_idx_q    <= digit_idx_d;
      last_digit_q   <= last_digit_d;
      enable_comp_q  <= enable_comp_d;
      enc_error_q    <= enc_error_d;
    end
  end

  assign load_ready  = !pending_full_q;
  assign x_digit     = x_digit_q;
  assign y_digit     = y_digit_q;
  assign enable_comp = enable_comp_q;
  assign digit_idx   = digit_idx_q;
  assign last_digit  = last_digit_q;
  assign enc_error   = enc_error_q;

endmodule

// File: tb/tb_sd_operand_feeder.sv
module tb_sd_operand_feeder;

  localparam int U  = 64;
  localparam int D  = 2;
  localparam int CW = 11;
  localparam int N  = U + D;

  logic            clk = 1'b0;
  logic            asyn_reset_n = 1'b1;
  logic            flush = 1'b0;
  logic            load_valid = 1'b0;
  logic            load_ready;
  logic [2*U-1:0]  x_vec = '0;
  logic [2*U-1:0]  y_vec = '0;
  logic            digit_req = 1'b0;
  logic [1:0]      x_digit, y_digit;
  logic            enable_comp;
  logic [CW-1:0]   digit_idx;
  logic            last_digit;
  logic            enc_error;

  sd_operand_feeder #(.UNROLLING(U), .ONLINE_DELAY(D), .CNT_W(CW)) dut (
    .clk          (clk),
    .asyn_reset_n (asyn_reset_n),
    .flush        (flush),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .x_vec        (x_vec),
    .y_vec        (y_vec),
    .digit_req    (digit_req),
    .x_digit      (x_digit),
    .y_digit      (y_digit),
    .enable_comp  (enable_comp),
    .digit_idx    (digit_idx),
    .last_digit   (last_digit),
    .enc_error    (enc_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    x;
    logic [1:0]    y;
    logic [CW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  int            total  = 0;
  int            passed = 0;
  logic [1:0]    held_x = 2'b00;
  logic [1:0]    held_y = 2'b00;
  logic [CW-1:0] held_idx = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
  endtask

  // Expected stream for one vector: MSD first, illegal digits as zero, then pads.
  task automatic push_vector(input logic [2*U-1:0] xv, input logic [2*U-1:0] yv);
    exp_t e;
    int   pos;
    for (int k = 0; k < N; k++) begin
      e.x = 2'b00;
      e.y = 2'b00;
      if (k < U) begin
        pos = U - 1 - k;
        e.x = xv[2*pos +: 2];
        e.y = yv[2*pos +: 2];
        if (e.x == 2'b11) e.x = 2'b00;
        if (e.y == 2'b11) e.y = 2'b00;
      end
      e.idx  = CW'(k);
      e.last = (k == N - 1);
      exp_q.push_back(e);
    end
  endtask

  // One clock; either a digit pair is due (popped from the scoreboard) or
  // the outputs must hold their previous value.
  task automatic step(input logic req, input bit expect_digit, input logic exp_en);
    exp_t e;
    digit_req = req;
    @(posedge clk); #1;
    if (expect_digit) begin
      chk("sb_nonempty", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        held_x = e.x;
        held_y = e.y;
        held_idx = e.idx;
        $display("digit idx=%0d x=%b y=%b last=%b", digit_idx, x_digit, y_digit, last_digit);
        chk("x_digit", 32'(x_digit), 32'(e.x));
        chk("y_digit", 32'(y_digit), 32'(e.y));
        chk("digit_idx", 32'(digit_idx), 32'(e.idx));
        chk("last_digit", 32'(last_digit), 32'(e.last));
      end
    end else begin
      chk("hold_x", 32'(x_digit), 32'(held_x));
      chk("hold_y", 32'(y_digit), 32'(held_y));
      chk("hold_idx", 32'(digit_idx), 32'(held_idx));
      chk("hold_last", 32'(last_digit), 32'd0);
    end
    chk("enable_comp", 32'(enable_comp), 32'(exp_en));
  endtask

  // Load into an idle feeder: PENDING fills, moves to ACTIVE, FSM enters STREAM.
  task automatic load_idle(input logic [2*U-1:0] xv, input logic [2*U-1:0] yv);
    x_vec = xv;
    y_vec = yv;
    load_valid = 1'b1;
    digit_req = 1'b0;
    @(posedge clk); #1;
    load_valid = 1'b0;
    $display("load x=%h y=%h", xv, yv);
    chk("load_ready_after_load", 32'(load_ready), 32'd0);
    push_vector(xv, yv);
    step(1'b0, 1'b0, 1'b0);
    chk("load_ready_after_move", 32'(load_ready), 32'd1);
    step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_x"}, 32'(x_digit), 32'd0);
    chk({tag, "_y"}, 32'(y_digit), 32'd0);
    chk({tag, "_en"}, 32'(enable_comp), 32'd0);
    chk({tag, "_idx"}, 32'(digit_idx), 32'd0);
    chk({tag, "_last"}, 32'(last_digit), 32'd0);
    chk({tag, "_ready"}, 32'(load_ready), 32'd1);
    chk({tag, "_enc"}, 32'(enc_error), 32'd0);
  endtask

  logic [2*U-1:0] x_ones, y_alt, x_neg, x_bad;

  initial begin
    for (int k = 0; k < U; k++) begin
      x_ones[2*k +: 2] = 2'b01;
      x_neg[2*k +: 2]  = 2'b10;
      y_alt[2*k +: 2]  = k[0] ? 2'b01 : 2'b10;  // MSD (k=63) is +1
    end
    x_bad = x_ones;
    x_bad[2*37 +: 2] = 2'b11;

    // Power-on reset
    #2 asyn_reset_n = 1'b0;
    #1 check_reset_outputs("por");
    @(posedge clk); #1;
    asyn_reset_n = 1'b1;
    $display("reset released");

    // Single vector, requests held high, then a request while idle
    load_idle(x_ones, y_alt);
    for (int i = 0; i < N; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);

    // Stalled requests: one every third cycle, outputs hold in between
    load_idle(x_ones, y_alt);
    for (int i = 0; i < N; i++) begin
      step(1'b1, 1'b1, 1'b1);
      if (i < N - 1) begin
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
      end
    end
    step(1'b0, 1'b0, 1'b0);

    // Back-to-back: B loaded during A's stream follows with no gap
    load_idle(x_ones, x_neg);
    for (int i = 0; i < 2 * N; i++) begin
      if (i == 5) begin
        x_vec = x_neg;
        y_vec = y_alt;
        load_valid = 1'b1;
      end
      step(1'b1, 1'b1, 1'b1);
      if (i == 5) begin
        load_valid = 1'b0;
        $display("load B x=%h y=%h", x_neg, y_alt);
        chk("b2b_ready_after_B", 32'(load_ready), 32'd0);
        push_vector(x_neg, y_alt);
      end
      if (i == N - 2) chk("b2b_ready_before_swap", 32'(load_ready), 32'd0);
      if (i == N - 1) chk("b2b_ready_after_swap", 32'(load_ready), 32'd1);
    end
    step(1'b1, 1'b0, 1'b0);

    // Illegal digit: sticky flag, digit emitted as zero
    chk("enc_before", 32'(enc_error), 32'd0);
    load_idle(x_bad, x_ones);
    chk("enc_after_load", 32'(enc_error), 32'd1);
    for (int i = 0; i < N; i++) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("enc_sticky", 32'(enc_error), 32'd1);

    // Asynchronous reset mid-stream right after digit 10
    load_idle(x_ones, y_alt);
    for (int i = 0; i <= 10; i++) step(1'b1, 1'b1, 1'b1);
    #2 asyn_reset_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    asyn_reset_n = 1'b1;
    $display("reset mid-stream released");
    exp_q.delete();
    held_x = 2'b00;
    held_y = 2'b00;
    held_idx = '0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);

    // Flush during PAD with PENDING full
    load_idle(x_neg, y_alt);
    for (int i = 0; i <= U; i++) begin
      if (i == 3) begin
        x_vec = x_ones;
        y_vec = x_ones;
        load_valid = 1'b1;
      end
      step(1'b1, 1'b1, 1'b1);
      if (i == 3) load_valid = 1'b0;
    end
    chk("flush_pending_full", 32'(load_ready), 32'd0);
    flush = 1'b1;
    digit_req = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    $display("flush applied");
    check_reset_outputs("flush");
    exp_q.delete();
    held_x = 2'b00;
    held_y = 2'b00;
    held_idx = '0;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
